motor_pwm_driver: RTL

//  Consumes the signed millipercent command from pid_control and drives the linear-actuator motor stage.

---
 rtl/motor_pwm_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/motor_pwm_driver.sv
// Motor stage driver: clamps and deadbands the PID command, then slew-limits it.
// It also sequences direction reversals through a braked dead-time and generates the PWM.
module motor_pwm_driver #(
  parameter int MAX_CMD      = 100000,
  parameter int DEADBAND     = 13000,
  parameter int SLEW_STEP    = 5000,
  parameter int PWM_STEP     = 100,
  parameter int DIR_DEADTIME = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] control,
  input  logic        control_valid,
  output logic        pwm_out,
  output logic        dir_out,
  output logic        brake_out,
  output logic [31:0] applied,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEADTIME = 2'd2
  } state_e;

  localparam logic signed [31:0] MAX_S    = MAX_CMD;
  localparam logic signed [31:0] DB_S     = DEADBAND;
  localparam logic signed [31:0] SLEW_S   = SLEW_STEP;
  localparam logic        [31:0] PWM_INC  = PWM_STEP;
  localparam logic        [31:0] PWM_LAST = MAX_CMD - PWM_STEP;
  localparam int                 DT_W     = $clog2(DIR_DEADTIME);
  localparam logic [DT_W-1:0]    DT_LAST  = DT_W'(DIR_DEADTIME - 1);

  state_e             state_q, state_d;
  logic signed [31:0] applied_q, applied_d;
  logic signed [31:0] target_q, target_d;
  logic        [31:0] cnt_q, cnt_d;
  logic        [31:0] shadow_q, shadow_d;
  logic [DT_W-1:0]    dt_cnt_q, dt_cnt_d;
  logic               dir_q, dir_d;
  logic               brake_q, brake_d;
  logic               pwm_q, pwm_d;

  logic signed [31:0] ctrl_s, clamped, mag, new_target, diff, slewed;
  logic        [31:0] applied_abs;
  logic               opposite, enter_dt, cnt_wrap;

  // Clamp runs before any magnitude so -2^31 can never overflow the abs.
  always_comb begin
    ctrl_s = $signed(control);
    if (ctrl_s > MAX_S)       clamped = MAX_S;
    else if (ctrl_s < -MAX_S) clamped = -MAX_S;
    else                      clamped = ctrl_s;
    mag        = clamped[31] ? -clamped : clamped;
    new_target = (mag < DB_S) ? 32'sd0 : clamped;

    opposite = (new_target > 0 && !dir_q) || (new_target < 0 && dir_q);
    diff     = new_target - applied_q;
    if (!opposite) begin
      if (diff > SLEW_S)       slewed = applied_q + SLEW_S;
      else if (diff < -SLEW_S) slewed = applied_q - SLEW_S;
      else                     slewed = new_target;
    end else if (applied_q > SLEW_S) begin
      slewed = applied_q - SLEW_S;
    end else if (applied_q < -SLEW_S) begin
      slewed = applied_q + SLEW_S;
    end else begin
      slewed = 32'sd0;
    end
    enter_dt = opposite && (applied_q == 32'sd0);

    applied_abs = applied_q[31] ? 32'(-applied_q) : 32'(applied_q);
    cnt_wrap    = (cnt_q == PWM_LAST);
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
    cnt_d    = cnt_wrap ? '0 : cnt_q + PWM_INC;
    shadow_d = cnt_wrap ? applied_abs : shadow_q;
    applied_d = applied_q;
    target_d  = target_q;
    dir_d     = dir_q;
    brake_d   = brake_q;
    state_d   = state_q;
    dt_cnt_d  = dt_cnt_q;

    if (!enable) begin
      applied_d = '0;
      target_d  = '0;
      shadow_d  = '0;
      brake_d   = 1'b0;
      state_d   = IDLE;
      dt_cnt_d  = '0;
    end else if (state_q == DEADTIME) begin
      if (control_valid) target_d = new_target;
      if (dt_cnt_q == DT_LAST) begin
        dir_d    = !dir_q;
        brake_d  = 1'b0;
        state_d  = IDLE;
        dt_cnt_d = '0;
      end else begin
        dt_cnt_d = dt_cnt_q + 1'b1;
      end
    end else begin
      if (control_valid) begin
        target_d = new_target;
        if (enter_dt) begin
          state_d  = DEADTIME;
          brake_d  = 1'b1;
          dt_cnt_d = '0;
        end else begin
          applied_d = slewed;
        end
      end
      if (state_d != DEADTIME) state_d = (applied_d != 32'sd0) ? RUN : IDLE;
    end

    pwm_d = (cnt_d < shadow_d) && (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (reset) begin
      state_q   <= IDLE;
      applied_q <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      dt_cnt_q  <= '0;
      dir_q     <= 1'b1;
      brake_q   <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      applied_q <= applied_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      dt_cnt_q  <= dt_cnt_d;
      dir_q     <= dir_d;
      brake_q   <= brake_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign dir_out   = dir_q;
  assign brake_out = brake_q;
  assign applied   = applied_q;
  assign state_out = state_q;

endmodule
